// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder sequencer: one 4-bit ripple slice, one nibble per clock, LS nibble first.
// sum/cout are committed only on entry to DONE, so they never expose partial results.

module nsa_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] areg, breg, psum, psum_nx;
  logic [CW+1:0]    nidx;
  logic [3:0]       s;
  logic             c;
  logic             accept;

  assign nidx = {cnt, 2'b00};

  nsa_slice u_slice (
    .a  (areg[nidx +: 4]),
    .b  (breg[nidx +: 4]),
    .ci (carry),
    .s  (s),
    .co (c)
  );

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    psum_nx  = psum;
    psum_nx[nidx +: 4] = s;
    case (state)
      IDLE: if (start) begin
        accept   = 1'b1;
        state_nx = RUN;
      end
      RUN: if (cnt == LAST) state_nx = DONE;
      DONE: begin
        accept   = start;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      areg  <= '0;
      breg  <= '0;
      psum  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        areg  <= a;
        breg  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        psum  <= psum_nx;
        carry <= c;
        if (cnt == LAST) begin
          sum  <= psum_nx;
          cout <= c;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
